// File: rtl/game_move_sequencer.sv
// 2048 move sequencer: owns the 4x4 exponent board and streams its lines through an external merge unit.
// Optional SPAWN_FOUR_EN: spawned tile is exponent 2 when lfsr[7:5]==3'b111, otherwise exponent 1.
//
// state  | meaning
// IDLE   | waiting for a clean one-hot button press
// REQ    | presenting line k to the merge unit, writing results back
// SPAWN  | placing a new tile after a move that changed the board
// CHECK  | evaluating win / loss
// INIT   | placing the two starting tiles after reset
// LOSE   | terminal, no move possible
// WIN    | terminal, a tile reached WIN_EXP
module game_move_sequencer #(
    parameter int unsigned WIN_EXP   = 11,
    parameter logic [7:0]  LFSR_SEED = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pushbutts,
    output logic        mrg_req,
    output logic [15:0] mrg_line_in,
    input  logic        mrg_ack,
    input  logic [15:0] mrg_line_out,
    input  logic        mrg_moved,
    output logic [63:0] board,
    output logic        busy,
    output logic        victoria,
    output logic        derrota,
    output logic [2:0]  stateout
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_REQ   = 3'b001,
        ST_SPAWN = 3'b010,
        ST_CHECK = 3'b011,
        ST_INIT  = 3'b100,
        ST_LOSE  = 3'b101,
        ST_WIN   = 3'b110
    } state_t;

    state_t      r_state;
    logic [63:0] r_board;
    logic [3:0]  r_prev_btn;
    logic [3:0]  r_dir;
    logic [1:0]  r_k;
    logic        r_acc;
    logic [7:0]  r_lfsr;
    logic        r_init_second;

    logic [15:0] w_empty;
    logic        w_spawn_found;
    logic [3:0]  w_spawn_idx;
    logic [3:0]  w_scan_idx;
    logic [3:0]  w_spawn_val;
    logic        w_any_win;
    logic        w_pair;
    logic        w_press;
    logic        w_lfsr_fb;

    // Cell index {row,col} of a lane; lane0 is the cell against the wall the tiles slide toward.
    function automatic logic [3:0] cell_idx(input logic [3:0] dir, input logic [1:0] k,
                                            input logic [1:0] lane);
        logic [1:0] rev;
        rev = 2'd3 - lane;
        case (dir)
            4'b1000: cell_idx = {lane, k};
            4'b0100: cell_idx = {rev, k};
            4'b0010: cell_idx = {k, lane};
            default: cell_idx = {k, rev};
        endcase
    endfunction

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_press   = (pushbutts != 4'b0000) && ((pushbutts & (pushbutts - 4'd1)) == 4'b0000)
                       && (r_prev_btn == 4'b0000);

`ifdef SPAWN_FOUR_EN
    assign w_spawn_val = (r_lfsr[7:5] == 3'b111) ? 4'd2 : 4'd1;
`else
    assign w_spawn_val = 4'd1;
`endif

    always_comb begin
        mrg_line_in = '0;
        for (int j = 0; j < 4; j++) begin
            mrg_line_in[4*j +: 4] = r_board[{cell_idx(r_dir, r_k, 2'(j)), 2'b00} +: 4];
        end
    end

    always_comb begin
        w_empty   = '0;
        w_any_win = 1'b0;
        for (int i = 0; i < 16; i++) begin
            w_empty[i] = (r_board[4*i +: 4] == 4'd0);
            if (32'(r_board[4*i +: 4]) >= WIN_EXP) w_any_win = 1'b1;
        end
    end

    always_comb begin
        w_pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (r_board[16*r + 4*c +: 4] == r_board[16*r + 4*c + 4 +: 4]) w_pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_board[16*r + 4*c +: 4] == r_board[16*r + 4*c + 16 +: 4]) w_pair = 1'b1;
            end
        end
    end

    // First empty cell scanning upward from the LFSR start point, wrapping mod 16.
    always_comb begin
        w_spawn_found = 1'b0;
        w_spawn_idx   = 4'd0;
        w_scan_idx    = 4'd0;
        for (int i = 0; i < 16; i++) begin
            w_scan_idx = r_lfsr[3:0] + 4'(i);
            if (!w_spawn_found && w_empty[w_scan_idx]) begin
                w_spawn_found = 1'b1;
                w_spawn_idx   = w_scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_board       <= '0;
            r_prev_btn    <= '0;
            r_dir         <= 4'b0010;
            r_k           <= '0;
            r_acc         <= 1'b0;
            r_lfsr        <= LFSR_SEED;
            r_init_second <= 1'b0;
        end else begin
            r_prev_btn <= pushbutts;
            r_lfsr     <= {r_lfsr[6:0], w_lfsr_fb};
            case (r_state)
                ST_INIT: begin
                    if (w_spawn_found) r_board[{w_spawn_idx, 2'b00} +: 4] <= w_spawn_val;
                    r_init_second <= 1'b1;
                    if (r_init_second) r_state <= ST_CHECK;
                end
                ST_IDLE: begin
                    if (w_press) begin
                        r_dir   <= pushbutts;
                        r_k     <= 2'd0;
                        r_acc   <= 1'b0;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mrg_ack) begin
                        for (int j = 0; j < 4; j++) begin
                            r_board[{cell_idx(r_dir, r_k, 2'(j)), 2'b00} +: 4] <= mrg_line_out[4*j +: 4];
                        end
                        r_acc <= r_acc | mrg_moved;
                        r_k   <= r_k + 2'd1;
                        if (r_k == 2'd3) r_state <= (r_acc | mrg_moved) ? ST_SPAWN : ST_IDLE;
                    end
                end
                ST_SPAWN: begin
                    if (w_spawn_found) r_board[{w_spawn_idx, 2'b00} +: 4] <= w_spawn_val;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_any_win)                    r_state <= ST_WIN;
                    else if (!(|w_empty) && !w_pair)  r_state <= ST_LOSE;
                    else                              r_state <= ST_IDLE;
                end
                ST_WIN, ST_LOSE: r_state <= r_state;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign mrg_req  = (r_state == ST_REQ);
    assign board    = r_board;
    assign busy     = !((r_state == ST_IDLE) || (r_state == ST_WIN) || (r_state == ST_LOSE));
    assign victoria = (r_state == ST_WIN);
    assign derrota  = (r_state == ST_LOSE);
    assign stateout = r_state;

endmodule

// File: tb/tb_game_move_sequencer.sv
// Bench for game_move_sequencer: directed moves against a rule-level game model plus a scripted merge unit.
`timescale 1ns/1ps
module tb_game_move_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pushbutts = 4'b0000;
    logic        mrg_req;
    logic [15:0] mrg_line_in;
    logic        mrg_ack = 1'b0;
    logic [15:0] mrg_line_out = 16'h0000;
    logic        mrg_moved = 1'b0;
    logic [63:0] board;
    logic        busy, victoria, derrota;
    logic [2:0]  stateout;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [63:0] BOOT_BOARD = 64'h0000_0100_0001_0000;

    game_move_sequencer #(.WIN_EXP(11), .LFSR_SEED(8'h5A)) dut (
        .clk(clk), .rst(rst), .pushbutts(pushbutts),
        .mrg_req(mrg_req), .mrg_line_in(mrg_line_in), .mrg_ack(mrg_ack),
        .mrg_line_out(mrg_line_out), .mrg_moved(mrg_moved),
        .board(board), .busy(busy), .victoria(victoria), .derrota(derrota),
        .stateout(stateout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- merge unit (stimulus side) ----------------
    function automatic logic [15:0] merge_ref(input logic [15:0] li);
        int c[4];
        int o[4];
        int n, m, i;
        logic [15:0] r;
        n = 0; m = 0;
        for (int q = 0; q < 4; q++) begin c[q] = 0; o[q] = 0; end
        for (int q = 0; q < 4; q++) if (li[4*q +: 4] != 4'd0) begin c[n] = int'(li[4*q +: 4]); n++; end
        i = 0;
        while (i < n) begin
            if (i + 1 < n && c[i] == c[i+1]) begin o[m] = c[i] + 1; i += 2; end
            else begin o[m] = c[i]; i += 1; end
            m++;
        end
        r = '0;
        for (int q = 0; q < 4; q++) r[4*q +: 4] = 4'(o[q]);
        return r;
    endfunction

    int          mode = 0;      // 0 real merge, 1 scripted lines, 2 unchanged / not moved
    int          stall_n = 0;
    int          wait_cnt = 0;
    int          xfer_k = 0;
    logic [15:0] scr_line [4];
    logic [3:0]  scr_mask = 4'b0000;

    always @(posedge clk) begin
        #2;
        if (mrg_ack) xfer_k = (xfer_k + 1) % 4;
        if (!mrg_req) begin
            wait_cnt = 0; xfer_k = 0; mrg_ack = 1'b0; mrg_moved = 1'b0; mrg_line_out = 16'h0000;
        end else if (wait_cnt < stall_n) begin
            wait_cnt++; mrg_ack = 1'b0;
        end else begin
            wait_cnt = 0; mrg_ack = 1'b1;
            case (mode)
                0: begin mrg_line_out = merge_ref(mrg_line_in); mrg_moved = (mrg_line_out != mrg_line_in); end
                1: begin mrg_line_out = scr_line[xfer_k]; mrg_moved = scr_mask[xfer_k]; end
                default: begin mrg_line_out = mrg_line_in; mrg_moved = 1'b0; end
            endcase
        end
    end

    // ---------------- game model ----------------
    localparam int S_IDLE = 0, S_REQ = 1, S_SPAWN = 2, S_CHECK = 3, S_INIT = 4, S_LOSE = 5, S_WIN = 6;
    int         m_cell [16];
    int         m_st = S_INIT;
    int         m_k = 0;
    int         m_init_left = 2;
    bit         m_acc = 1'b0;
    bit         m_valid = 1'b0;
    logic [3:0] m_dir = 4'b0010;
    logic [3:0] m_prev = 4'b0000;
    logic [7:0] m_lfsr = 8'h5A;

    function automatic int line_cell(input logic [3:0] d, input int k, input int lane);
        case (d)
            4'b0010: return 4*k + lane;
            4'b0001: return 4*k + (3 - lane);
            4'b1000: return 4*lane + k;
            default: return 4*(3 - lane) + k;
        endcase
    endfunction

    task automatic model_spawn();
        int idx;
        int val;
        val = 1;
`ifdef SPAWN_FOUR_EN
        if (m_lfsr[7:5] == 3'b111) val = 2;
`endif
        for (int i = 0; i < 16; i++) begin
            idx = (int'(m_lfsr[3:0]) + i) % 16;
            if (m_cell[idx] == 0) begin m_cell[idx] = val; break; end
        end
    endtask

    function automatic int model_verdict();
        bit full, pair;
        full = 1'b1; pair = 1'b0;
        foreach (m_cell[i]) begin
            if (m_cell[i] >= 11) return S_WIN;
            if (m_cell[i] == 0) full = 1'b0;
            if (i % 4 != 3 && m_cell[i] == m_cell[i+1]) pair = 1'b1;
            if (i < 12 && m_cell[i] == m_cell[i+4]) pair = 1'b1;
        end
        return (full && !pair) ? S_LOSE : S_IDLE;
    endfunction

    function automatic logic [63:0] model_board();
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[4*i +: 4] = 4'(m_cell[i]);
        return b;
    endfunction

    function automatic logic [15:0] model_line();
        logic [15:0] l;
        l = '0;
        for (int j = 0; j < 4; j++) l[4*j +: 4] = 4'(m_cell[line_cell(m_dir, m_k, j)]);
        return l;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_cell[i]) m_cell[i] = 0;
            m_st = S_INIT; m_lfsr = 8'h5A; m_prev = 4'b0000; m_init_left = 2; m_valid = 1'b1;
        end else begin
            case (m_st)
                S_INIT: begin
                    model_spawn();
                    m_init_left--;
                    if (m_init_left == 0) m_st = S_CHECK;
                end
                S_IDLE: if ($countones(pushbutts) == 1 && m_prev == 4'b0000) begin
                    m_dir = pushbutts; m_k = 0; m_acc = 1'b0; m_st = S_REQ;
                end
                S_REQ: if (mrg_ack) begin
                    for (int j = 0; j < 4; j++) m_cell[line_cell(m_dir, m_k, j)] = int'(mrg_line_out[4*j +: 4]);
                    m_acc = m_acc | mrg_moved;
                    if (m_k == 3) m_st = m_acc ? S_SPAWN : S_IDLE;
                    m_k = (m_k + 1) % 4;
                end
                S_SPAWN: begin model_spawn(); m_st = S_CHECK; end
                S_CHECK: m_st = model_verdict();
                default: ;
            endcase
            m_prev = pushbutts;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("stateout", 64'(stateout), 64'(m_st));
            check("busy", 64'(busy), 64'(!(m_st == S_IDLE || m_st == S_WIN || m_st == S_LOSE)));
            check("victoria", 64'(victoria), 64'(m_st == S_WIN));
            check("derrota", 64'(derrota), 64'(m_st == S_LOSE));
            check("mrg_req", 64'(mrg_req), 64'(m_st == S_REQ));
            check("board", board, model_board());
            if (m_st == S_REQ) check("mrg_line_in", 64'(mrg_line_in), 64'(model_line()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_state(input logic [2:0] target, input int bound, output int edges);
        edges = 0;
        while (stateout !== target && edges < bound) begin step(1); edges++; end
        check("reach_state", 64'(stateout), 64'(target));
    endtask

    task automatic press_move(input logic [3:0] btn, output int edges);
        pushbutts = btn;
        step(1);
        pushbutts = 4'b0000;
        wait_state(3'b000, 100, edges);
    endtask

    task automatic set_script(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                              input logic [15:0] l3, input logic [3:0] mask);
        scr_line[0] = l0; scr_line[1] = l1; scr_line[2] = l2; scr_line[3] = l3;
        scr_mask = mask; mode = 1;
    endtask

    task automatic do_boot();
        rst = 1'b1; step(2);
        check("rst_state", 64'(stateout), 64'h4);
        check("rst_board", board, 64'h0);
        check("rst_req", 64'(mrg_req), 64'h0);
        check("rst_busy", 64'(busy), 64'h1);
        rst = 1'b0;
        step(1); check("boot_s1", 64'(stateout), 64'h4);
        step(1); check("boot_s2", 64'(stateout), 64'h3);
        step(1); check("boot_s3", 64'(stateout), 64'h0);
        check("boot_busy", 64'(busy), 64'h0);
        check("boot_board", board, BOOT_BOARD);
    endtask

    initial begin
        int e, cnt, last;
        for (int q = 0; q < 4; q++) scr_line[q] = 16'h0000;

        do_boot();

        // load row0 = {1,1,0,0} through an unmoved scripted writeback
        set_script(16'h0011, 16'h0000, 16'h0000, 16'h0000, 4'b0000);
        press_move(4'b0010, e);
        check("load_edges", 64'(e), 64'd4);
        check("load_board", board, 64'h0011);

        // left move with real merge
        mode = 0;
        pushbutts = 4'b0010;
        step(1);
        pushbutts = 4'b0000;
        check("left_req", 64'(mrg_req), 64'h1);
        check("left_line0", 64'(mrg_line_in), 64'h0011);
        step(1);
        check("left_wb", board, 64'h0002);
        wait_state(3'b000, 100, e);
        check("left_edges", 64'(e + 1), 64'd6);
        cnt = 0;
        for (int i = 0; i < 16; i++) if (board[4*i +: 4] != 4'd0) cnt++;
        check("left_tiles", 64'(cnt), 64'd2);
        check("left_cell0", 64'(board[3:0]), 64'h2);

        // stalled merge: 3 wait cycles per line
        stall_n = 3;
        pushbutts = 4'b0001;
        step(1);
        pushbutts = 4'b0000;
        cnt = 0;
        while (stateout == 3'b001 && cnt < 100) begin cnt++; step(1); end
        check("stall_req_cycles", 64'(cnt), 64'd16);
        wait_state(3'b000, 100, e);
        stall_n = 0;

        // merge reports no movement
        mode = 2;
        press_move(4'b1000, e);
        check("nomove_edges", 64'(e), 64'd4);
        mode = 0;

        // multi-hot ignored
        pushbutts = 4'b0011;
        step(1);
        check("multihot_state", 64'(stateout), 64'h0);
        step(3);
        pushbutts = 4'b0000;
        check("multihot_busy", 64'(busy), 64'h0);
        step(1);

        // held button moves once
        pushbutts = 4'b0001;
        cnt = 0; last = 0;
        repeat (20) begin
            step(1);
            if (stateout == 3'b001 && last != 1) cnt++;
            last = int'(stateout);
        end
        check("held_moves", 64'(cnt), 64'd1);
        pushbutts = 4'b0000;
        step(1);

        // merge produces a 2048 tile
        set_script(16'h000B, 16'h0000, 16'h0000, 16'h0000, 4'b0001);
        pushbutts = 4'b0010;
        step(1);
        pushbutts = 4'b0000;
        wait_state(3'b110, 50, e);
        check("win_edges", 64'(e), 64'd6);
        check("win_flag", 64'(victoria), 64'h1);
        check("win_derrota", 64'(derrota), 64'h0);
        check("win_cell0", 64'(board[3:0]), 64'hB);
        mode = 0;
        pushbutts = 4'b1000;
        step(1);
        pushbutts = 4'b0000;
        step(3);
        check("win_terminal", 64'(stateout), 64'h6);
        check("win_no_req", 64'(mrg_req), 64'h0);

        do_boot();

        // checkerboard with one hole; the spawn fills it and no move remains
        set_script(16'h2120, 16'h1212, 16'h2121, 16'h1212, 4'b0001);
        pushbutts = 4'b0010;
        step(1);
        pushbutts = 4'b0000;
        wait_state(3'b101, 50, e);
        check("lose_flag", 64'(derrota), 64'h1);
        check("lose_victoria", 64'(victoria), 64'h0);
        check("lose_board", board, 64'h1212_2121_1212_2121);
        mode = 0;

        do_boot();

        // reset in the middle of the second line
        pushbutts = 4'b1000;
        step(1);
        pushbutts = 4'b0000;
        check("mid_line0", 64'(mrg_line_in), 64'h0010);
        step(1);
        check("mid_req_line1", 64'(mrg_req), 64'h1);
        rst = 1'b1;
        step(1);
        check("mid_req_drop", 64'(mrg_req), 64'h0);
        check("mid_board", board, 64'h0);
        check("mid_state", 64'(stateout), 64'h4);
        rst = 1'b0;
        step(3);
        check("mid_reboot_state", 64'(stateout), 64'h0);
        check("mid_reboot_board", board, BOOT_BOARD);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
